sd_req_arbiter: RTL

Serializes block requests from several virtual-disk clients (floppy track buffers, HDD controller) onto one hps_io SD request/ack channel. Grants one client at a time in round-robin order and drives the shared LBA and read/write strobes. Steers the 512-byte buffer data path to the granted client and reports completion or timeout per client. Sits between the drive controllers and hps_io in the emu top level.

---
 rtl/sd_req_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sd_req_arbiter.sv
`timescale 1ns/1ps
// sd_req_arbiter: round-robin arbiter that shares the hps_io SD request/ack
// channel among several virtual-disk clients and steers the buffer data path
// to the client that currently holds the grant.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | scan clients from last+1, latch grant/op/lba of the winner
// S_ISSUE | sd_rd/sd_wr held, waiting for a rising edge on sd_ack
// S_XFER  | buffer transfer in progress, waiting for sd_ack to fall
// S_DONE  | req_done pulse to the granted client, then back to idle
module sd_req_arbiter #(
   parameter int          NCLIENT = 3,
   parameter logic [23:0] TIMEOUT = 24'd0
) (
   input  logic                   clk_sys,
   input  logic                   reset_n,
   input  logic [NCLIENT-1:0]     req_rd,
   input  logic [NCLIENT-1:0]     req_wr,
   input  logic [32*NCLIENT-1:0]  req_lba,
   input  logic [8*NCLIENT-1:0]   req_din,
   output logic [NCLIENT-1:0]     req_done,
   output logic [NCLIENT-1:0]     req_err,
   output logic [NCLIENT-1:0]     req_buff_wr,
   output logic [31:0]            sd_lba,
   output logic                   sd_rd,
   output logic                   sd_wr,
   input  logic                   sd_ack,
   input  logic                   sd_buff_wr,
   output logic [7:0]             sd_buff_din,
   output logic [2:0]             grant,
   output logic                   busy
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_DONE} state_t;

   state_t             state, state_nx;
   logic [2:0]         last, grant_nx, sel_idx;
   logic               sel_vld, sel_wr, op_wr, op_wr_nx;
   logic [31:0]        sel_lba, lba_nx;
   logic               old_ack, ack_rise, ack_fall, active, tmr_tc;
   logic [23:0]        tmr;
   logic [NCLIENT-1:0] req_any, done_nx, err_nx;
   logic               sd_rd_nx, sd_wr_nx;

   assign ack_rise = sd_ack & ~old_ack;
   assign ack_fall = ~sd_ack & old_ack;
   assign active   = (state == S_ISSUE) || (state == S_XFER);
   assign tmr_tc   = (TIMEOUT != 24'd0) && active && (tmr == 24'd1);
   // a client still holds its request during the idle cycle right after a
   // timeout pulse; masking by req_done keeps it from being re-granted
   assign req_any  = (req_rd | req_wr) & ~req_done;

   // round-robin pick: lowest requester above last wins, else lowest at/below it
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
      sel_wr  = 1'b0;
      sel_lba = '0;
      for (int i = NCLIENT-1; i >= 0; i--) begin
         if (req_any[i] && (3'(i) <= last)) begin
            sel_vld = 1'b1;
            sel_idx = 3'(i);
            sel_wr  = req_wr[i];
            sel_lba = req_lba[32*i +: 32];
         end
      end
      for (int i = NCLIENT-1; i >= 0; i--) begin
         if (req_any[i] && (3'(i) > last)) begin
            sel_vld = 1'b1;
            sel_idx = 3'(i);
            sel_wr  = req_wr[i];
            sel_lba = req_lba[32*i +: 32];
         end
      end
   end

   // state register, round-robin pointer, ack history and timeout down-counter
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         last    <= 3'(NCLIENT-1);
         old_ack <= 1'b0;
         tmr     <= '0;
      end else begin
         state   <= state_nx;
         old_ack <= sd_ack;
         if ((state == S_DONE) || tmr_tc)
            last <= grant;
         if ((state == S_IDLE) && (state_nx == S_ISSUE))
            tmr <= TIMEOUT;
         else if (active && (tmr != 24'd0))
            tmr <= tmr - 24'd1;
      end
   end

   // next-state decode
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (sel_vld) state_nx = S_ISSUE;
         S_ISSUE: if (tmr_tc) state_nx = S_IDLE;
                  else if (ack_rise) state_nx = S_XFER;
         S_XFER:  if (tmr_tc) state_nx = S_IDLE;
                  else if (ack_fall) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // next values of the registered outputs
   always_comb begin
      grant_nx = grant;
      op_wr_nx = op_wr;
      lba_nx   = sd_lba;
      if ((state == S_IDLE) && sel_vld) begin
         grant_nx = sel_idx;
         op_wr_nx = sel_wr;
         lba_nx   = sel_lba;
      end
      sd_rd_nx = (state_nx == S_ISSUE) && !op_wr_nx;
      sd_wr_nx = (state_nx == S_ISSUE) && op_wr_nx;
      done_nx  = '0;
      err_nx   = '0;
      for (int i = 0; i < NCLIENT; i++) begin
         done_nx[i] = (grant == 3'(i)) && ((state_nx == S_DONE) || tmr_tc);
         err_nx[i]  = (grant == 3'(i)) && tmr_tc;
      end
   end

   // output registers
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sd_rd    <= 1'b0;
         sd_wr    <= 1'b0;
         sd_lba   <= '0;
         grant    <= '0;
         op_wr    <= 1'b0;
         req_done <= '0;
         req_err  <= '0;
         busy     <= 1'b0;
      end else begin
         sd_rd    <= sd_rd_nx;
         sd_wr    <= sd_wr_nx;
         sd_lba   <= lba_nx;
         grant    <= grant_nx;
         op_wr    <= op_wr_nx;
         req_done <= done_nx;
         req_err  <= err_nx;
         busy     <= (state_nx != S_IDLE);
      end
   end

   // buffer data path follows the grant combinationally
   always_comb begin
      sd_buff_din = '0;
      req_buff_wr = '0;
      for (int i = 0; i < NCLIENT; i++) begin
         if (grant == 3'(i))
            sd_buff_din = req_din[8*i +: 8];
         req_buff_wr[i] = sd_buff_wr & sd_ack & (grant == 3'(i)) & (state == S_XFER);
      end
   end

endmodule
